// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_if
// Description : Bundles the fetch lookup, prediction and execute-training
//               signals of the branch predictor.
//               master : fetch/execute side (drives lookup, update, flush)
//               slave  : predictor (drives the predict_* outputs)
// Ports       : flush, lookup_valid, lookup_pc, predict_valid, predict_pc,
//               predict_taken, predict_target, update_valid, update_pc,
//               update_taken, update_target, update_uncond
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if;
    logic        flush;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        predict_valid;
    logic [31:0] predict_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_uncond;

    modport master (
        output flush, lookup_valid, lookup_pc,
        output update_valid, update_pc, update_taken, update_target, update_uncond,
        input  predict_valid, predict_pc, predict_taken, predict_target
    );

    modport slave (
        input  flush, lookup_valid, lookup_pc,
        input  update_valid, update_pc, update_taken, update_target, update_uncond,
        output predict_valid, predict_pc, predict_taken, predict_target
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit saturating direction counters.
//               One-cycle registered prediction, trained by resolved branches.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bp    - branch_predictor_if.slave (lookup/predict/update/flush)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES   = 64,
    parameter int TAG_WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    branch_predictor_if.slave bp
);
    localparam int IDX = $clog2(ENTRIES);

    // Table state. valid/ctr/uncond are reset; tag/target are gated by valid.
    logic [ENTRIES-1:0]   valid_q;
    logic [ENTRIES-1:0]   uncond_q;
    logic [1:0]           ctr_q    [ENTRIES];
    logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
    logic [31:0]          target_q [ENTRIES];

    // Prediction output registers
    logic        predict_valid_q, predict_valid_d;
    logic        predict_taken_q, predict_taken_d;
    logic [31:0] predict_pc_q,     predict_pc_d;
    logic [31:0] predict_target_q, predict_target_d;

    // ---------------- lookup path (reads pre-update contents) ----------------
    logic [IDX-1:0]       lk_idx;
    logic [TAG_WIDTH-1:0] lk_tag;
    logic                 lk_hit;
    logic                 lk_taken;

    assign lk_idx   = bp.lookup_pc[IDX+1:2];
    assign lk_tag   = bp.lookup_pc[IDX+1+TAG_WIDTH:IDX+2];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && (uncond_q[lk_idx] || ctr_q[lk_idx][1]);

    always_comb begin
        predict_valid_d  = bp.lookup_valid && !bp.flush;
        predict_pc_d     = predict_pc_q;
        predict_taken_d  = predict_taken_q;
        predict_target_d = predict_target_q;
        // Data registers only load on a surviving lookup; otherwise they hold.
        if (bp.lookup_valid && !bp.flush) begin
            predict_pc_d     = bp.lookup_pc;
            predict_taken_d  = lk_taken;
            predict_target_d = lk_taken ? target_q[lk_idx] : (bp.lookup_pc + 32'd8);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            predict_valid_q  <= 1'b0;
            predict_taken_q  <= 1'b0;
            predict_pc_q     <= 32'd0;
            predict_target_q <= 32'd0;
        end else begin
            predict_valid_q  <= predict_valid_d;
            predict_taken_q  <= predict_taken_d;
            predict_pc_q     <= predict_pc_d;
            predict_target_q <= predict_target_d;
        end
    end

    assign bp.predict_valid  = predict_valid_q;
    assign bp.predict_taken  = predict_taken_q;
    assign bp.predict_pc     = predict_pc_q;
    assign bp.predict_target = predict_target_q;

    // ---------------- training path ----------------
    logic [IDX-1:0]       up_idx;
    logic [TAG_WIDTH-1:0] up_tag;
    logic                 up_hit;
    logic                 wr_en;
    logic [1:0]           ctr_d;
    logic                 uncond_d;
    logic [31:0]          target_d;

    assign up_idx = bp.update_pc[IDX+1:2];
    assign up_tag = bp.update_pc[IDX+1+TAG_WIDTH:IDX+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        wr_en    = 1'b0;
        ctr_d    = ctr_q[up_idx];
        uncond_d = bp.update_uncond;
        target_d = target_q[up_idx];
        if (bp.update_valid) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (bp.update_taken) begin
                    ctr_d    = (ctr_q[up_idx] == 2'd3) ? 2'd3 : ctr_q[up_idx] + 2'd1;
                    target_d = bp.update_target;
                end else begin
                    ctr_d    = (ctr_q[up_idx] == 2'd0) ? 2'd0 : ctr_q[up_idx] - 2'd1;
                end
                if (bp.update_uncond) begin
                    ctr_d = 2'd3;
                end
            end else if (bp.update_taken) begin
                // Miss + taken: allocate over whatever lives at this index.
                wr_en    = 1'b1;
                ctr_d    = bp.update_uncond ? 2'd3 : 2'd2;
                target_d = bp.update_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            uncond_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (wr_en) begin
            valid_q[up_idx]  <= 1'b1;
            uncond_q[up_idx] <= uncond_d;
            ctr_q[up_idx]    <= ctr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= target_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor: directed scenarios
//               followed by random traffic, checked against a behavioural
//               table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;
    localparam int ENTRIES   = 64;
    localparam int TAG_WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if bp_if ();

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_WIDTH(TAG_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: one record per table slot, plain integers.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    bit [31:0]   m_target [ENTRIES];
    bit          m_uncond [ENTRIES];
    int          m_ctr    [ENTRIES];
    bit          e_valid, e_taken;
    bit [31:0]   e_pc, e_target;

    function automatic int unsigned slot_of(bit [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction
    function automatic int unsigned tag_of(bit [31:0] pc);
        return (pc / (4 * ENTRIES)) % (1 << TAG_WIDTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_ctr[i] = 1; m_uncond[i] = 0;
        end
        e_valid = 0; e_taken = 0; e_pc = 0; e_target = 0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(string tag, bit data_known);
        chk({tag, ".valid"}, {31'd0, bp_if.predict_valid}, {31'd0, e_valid});
        if (data_known) begin
            chk({tag, ".pc"},     bp_if.predict_pc,              e_pc);
            chk({tag, ".taken"},  {31'd0, bp_if.predict_taken},  {31'd0, e_taken});
            chk({tag, ".target"}, bp_if.predict_target,          e_target);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, check.
    bit data_known = 1;
    task automatic cyc(string tag, bit lv, bit [31:0] lpc, bit uv, bit [31:0] upc,
                       bit ut, bit [31:0] utgt, bit uu, bit fl);
        int unsigned s, t;
        bit hit;
        bp_if.lookup_valid = lv;  bp_if.lookup_pc = lpc;  bp_if.flush = fl;
        bp_if.update_valid = uv;  bp_if.update_pc = upc;  bp_if.update_taken = ut;
        bp_if.update_target = utgt; bp_if.update_uncond = uu;
        @(posedge clk);
        // lookup observes pre-update contents
        if (lv && !fl) begin
            s = slot_of(lpc); t = tag_of(lpc);
            hit = m_valid[s] && (m_tag[s] == t);
            e_valid  = 1;
            e_pc     = lpc;
            e_taken  = hit && (m_uncond[s] || m_ctr[s] >= 2);
            e_target = e_taken ? m_target[s] : lpc + 32'd8;
            data_known = 1;
        end else begin
            e_valid = 0;
            if (fl) data_known = 0;   // data after a flush is not characterised
        end
        if (uv) begin
            s = slot_of(upc); t = tag_of(upc);
            hit = m_valid[s] && (m_tag[s] == t);
            if (hit) begin
                if (ut) begin
                    m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
                    m_target[s] = utgt;
                end else begin
                    m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
                end
                m_uncond[s] = uu;
                if (uu) m_ctr[s] = 3;
            end else if (ut) begin
                m_valid[s] = 1; m_tag[s] = t; m_target[s] = utgt;
                m_uncond[s] = uu; m_ctr[s] = uu ? 3 : 2;
            end
        end
        #1;
        check_outputs(tag, data_known);
    endtask

    task automatic look(string tag, bit [31:0] pc);
        cyc(tag, 1, pc, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic upd(string tag, bit [31:0] pc, bit tk, bit [31:0] tgt, bit uu);
        cyc(tag, 0, 0, 1, pc, tk, tgt, uu, 0);
    endtask

    initial begin
        bp_if.flush = 0; bp_if.lookup_valid = 0; bp_if.lookup_pc = 0;
        bp_if.update_valid = 0; bp_if.update_pc = 0; bp_if.update_taken = 0;
        bp_if.update_target = 0; bp_if.update_uncond = 0;
        model_reset();
        #1;
        check_outputs("reset_async", 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        check_outputs("reset_state", 1);

        // Cold lookup
        look("cold", 32'hBFC0_0000);
        chk("cold.target_const", bp_if.predict_target, 32'hBFC0_0008);

        // First taken update allocates
        upd("alloc_upd", 32'h8000_0010, 1, 32'h8000_0100, 0);
        look("alloc_look", 32'h8000_0010);
        chk("alloc.target_const", bp_if.predict_target, 32'h8000_0100);

        // Counter hysteresis
        upd("hyst_nt1", 32'h8000_0010, 0, 0, 0);
        upd("hyst_nt2", 32'h8000_0010, 0, 0, 0);
        look("hyst_look0", 32'h8000_0010);
        chk("hyst0.target_const", bp_if.predict_target, 32'h8000_0018);
        upd("hyst_t1", 32'h8000_0010, 1, 32'h8000_0100, 0);
        look("hyst_look1", 32'h8000_0010);
        chk("hyst1.taken_const", {31'd0, bp_if.predict_taken}, 32'd0);
        upd("hyst_t2", 32'h8000_0010, 1, 32'h8000_0100, 0);
        look("hyst_look2", 32'h8000_0010);
        chk("hyst2.taken_const", {31'd0, bp_if.predict_taken}, 32'd1);

        // Aliasing: same index, different tag
        look("alias_miss", 32'h8000_0110);
        chk("alias.target_const", bp_if.predict_target, 32'h8000_0118);
        upd("alias_evict", 32'h8000_0110, 1, 32'h8000_1000, 1);
        look("alias_new", 32'h8000_0110);
        look("alias_old", 32'h8000_0010);
        chk("alias_old.taken_const", {31'd0, bp_if.predict_taken}, 32'd0);

        // Same-cycle update and lookup, then the follow-up lookup
        cyc("same_cycle", 1, 32'h8000_0020, 1, 32'h8000_0020, 1, 32'h8000_2000, 0, 0);
        chk("same_cycle.taken_const", {31'd0, bp_if.predict_taken}, 32'd0);
        look("same_next", 32'h8000_0020);
        chk("same_next.target_const", bp_if.predict_target, 32'h8000_2000);

        // Fall-through wraps modulo 2^32
        look("wrap", 32'hFFFF_FFFC);
        chk("wrap.target_const", bp_if.predict_target, 32'h0000_0004);

        // Idle cycle: valid drops, data holds
        cyc("idle", 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0);

        // Flush wins over a simultaneous lookup
        look("pre_flush", 32'h8000_0110);
        cyc("flush", 1, 32'h8000_0110, 0, 0, 0, 0, 0, 1);

        // Random traffic over a small PC pool to get hits and aliasing
        for (int i = 0; i < 400; i++) begin
            bit [31:0] lpc, upc, tgt;
            lpc = 32'h8000_0000 | ($urandom_range(0, 255) << 2);
            upc = 32'h8000_0000 | ($urandom_range(0, 255) << 2);
            tgt = $urandom & 32'hFFFF_FFFC;
            cyc("rand", ($urandom_range(0, 3) != 0), lpc,
                ($urandom_range(0, 1) == 1), upc, ($urandom_range(0, 2) != 0), tgt,
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0));
        end

        // Mid-stream reset: outputs clear without waiting for an edge
        upd("pre_rst_upd", 32'h8000_0040, 1, 32'h8000_4000, 0);
        look("pre_rst_look", 32'h8000_0040);
        chk("pre_rst.taken_const", {31'd0, bp_if.predict_taken}, 32'd1);
        bp_if.lookup_valid = 1; bp_if.lookup_pc = 32'h8000_0040;
        bp_if.update_valid = 0; bp_if.flush = 0;
        rst_n = 0;
        model_reset();
        data_known = 1;
        #1;
        check_outputs("rst_async", 1);
        #1 rst_n = 1;
        look("post_rst_a", 32'h8000_0040);
        chk("post_rst_a.taken_const", {31'd0, bp_if.predict_taken}, 32'd0);
        look("post_rst_b", 32'h8000_0110);
        look("post_rst_c", 32'h8000_0020);
        // ctr resets to 1: a fresh allocation then behaves as allocated (2)
        upd("post_rst_alloc", 32'h8000_0020, 1, 32'h8000_2220, 0);
        look("post_rst_d", 32'h8000_0020);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time limit so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
